// File: rtl/spi_tx_scheduler_pkg.sv
// Shared types and default constants for the SPI transmit scheduler.
package spi_pkg;

  // Frame sequencer states; the encoding is fixed so the state can be decoded externally.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StGap   = 2'd3
  } state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDiv   = 4;
  localparam int unsigned DefGap   = 2;

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// Requester/pin bundle of the SPI transmit scheduler.
// master: host-side producers and pin observers. slave: the scheduler itself.
interface spi_tx_scheduler_if #(
  parameter int unsigned DATA_W = spi_pkg::DefDataW
) ();
  logic [1:0]        REQ;
  logic [DATA_W-1:0] DATA0;
  logic [DATA_W-1:0] DATA1;
  logic [1:0]        GNT;
  logic              BUSY;
  logic              DONE;
  logic              SCLK;
  logic              MOSI;
  logic              SS_N;
  logic              SH_LD;
  logic              TE;
  logic [3:0]        BIT_CNT;

  modport master (
    output REQ, DATA0, DATA1,
    input  GNT, BUSY, DONE, SCLK, MOSI, SS_N, SH_LD, TE, BIT_CNT
  );

  modport slave (
    input  REQ, DATA0, DATA1,
    output GNT, BUSY, DONE, SCLK, MOSI, SS_N, SH_LD, TE, BIT_CNT
  );
endinterface

// File: rtl/spi_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the winner is registered when upd_i is high.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       last_i,
  output logic       sel_o
);
  logic sel_d, sel_q;

  // Lone request wins outright; a tie goes to the requester not granted last.
  always_comb begin
    sel_d = sel_q;
    if (upd_i) begin
      unique case (req_i)
        2'b01:   sel_d = 1'b0;
        2'b10:   sel_d = 1'b1;
        2'b11:   sel_d = ~last_i;
        default: sel_d = sel_q;
      endcase
    end
  end

  // Winner register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sel_q <= 1'b0;
    else         sel_q <= sel_d;
  end

  assign sel_o = sel_q;
endmodule

// File: rtl/spi_tx_scheduler.sv
// Two-requester SPI transmit scheduler: arbitrates, loads the winning byte and
// shifts it out MSB first with a divided SCLK, then holds SS_N high for a gap.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DIV    = DefDiv,
  parameter int unsigned GAP    = DefGap
) (
  input logic              CLK,
  input logic              CLR,
  spi_tx_scheduler_if.slave bus
);
  localparam logic [7:0] DivLast = 8'(DIV - 1);
  localparam logic [7:0] GapLast = 8'(GAP - 1);
  localparam logic [3:0] BitLast = 4'(DATA_W - 1);

  state_e            state_d, state_q;
  logic [DATA_W-1:0] sr_d, sr_q;
  logic [7:0]        div_d, div_q;
  logic [7:0]        gap_d, gap_q;
  logic [3:0]        bit_d, bit_q;
  logic              sclk_d, sclk_q;
  logic              ptr_d, ptr_q;
  logic              sel;
  logic              arb_upd;

  assign arb_upd = (state_q == StIdle) && (bus.REQ != 2'b00);

  rr_arbiter2 u_arb (
    .clk_i  (CLK),
    .rst_ni (CLR),
    .req_i  (bus.REQ),
    .upd_i  (arb_upd),
    .last_i (ptr_q),
    .sel_o  (sel)
  );

  // Next-state logic for the sequencer, shift register, divider and counters.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_upd) state_d = StLoad;
      end
      StLoad: begin
        sr_d    = sel ? bus.DATA1 : bus.DATA0;
        ptr_d   = sel;
        div_d   = 8'd0;
        sclk_d  = 1'b0;
        bit_d   = 4'd0;
        state_d = StShift;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          // Falling SCLK edge: the current bit has been sampled, advance.
          if (sclk_q) begin
            sr_d  = {sr_q[DATA_W-2:0], 1'b0};
            bit_d = bit_q + 4'd1;
            if (bit_q == BitLast) begin
              gap_d   = 8'd0;
              state_d = StGap;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          bit_d   = 4'd0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset leaves requester 1 as last-granted so requester 0 wins the first tie.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= StIdle;
      sr_q    <= '0;
      div_q   <= 8'd0;
      gap_q   <= 8'd0;
      bit_q   <= 4'd0;
      sclk_q  <= 1'b0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.GNT     = 2'b00;
    if (state_q == StLoad) bus.GNT = sel ? 2'b10 : 2'b01;
    bus.BUSY    = (state_q != StIdle);
    bus.DONE    = (state_q == StGap) && (gap_q == 8'd0);
    bus.SCLK    = sclk_q;
    bus.MOSI    = (state_q == StShift) && sr_q[DATA_W-1];
    bus.SS_N    = !((state_q == StLoad) || (state_q == StShift));
    bus.SH_LD   = (state_q != StLoad);
    bus.TE      = (state_q == StShift);
    bus.BIT_CNT = bit_q;
  end
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Self-checking bench for spi_tx_scheduler: directed and randomized frames
// compared against a frame-level model of arbitration, payload and timing.
module tb_spi_tx_scheduler;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       clr0, clr1;
  logic [1:0] req;
  logic [7:0] d0, d1;
  logic       use1;

  spi_tx_scheduler_if #(.DATA_W(8)) b0 ();
  spi_tx_scheduler_if #(.DATA_W(8)) b1 ();

  assign b0.REQ = req;
  assign b0.DATA0 = d0;
  assign b0.DATA1 = d1;
  assign b1.REQ = req;
  assign b1.DATA0 = d0;
  assign b1.DATA1 = d1;

  spi_tx_scheduler #(.DATA_W(8), .DIV(4), .GAP(2)) dut0 (.CLK(clk), .CLR(clr0), .bus(b0));
  spi_tx_scheduler #(.DATA_W(8), .DIV(1), .GAP(1)) dut1 (.CLK(clk), .CLR(clr1), .bus(b1));

  // Observed pins of the instance under test.
  logic [1:0] m_gnt;
  logic [3:0] m_bitcnt;
  logic       m_busy, m_done, m_sclk, m_mosi, m_ssn, m_shld, m_te;
  assign m_gnt    = use1 ? b1.GNT : b0.GNT;
  assign m_bitcnt = use1 ? b1.BIT_CNT : b0.BIT_CNT;
  assign m_busy   = use1 ? b1.BUSY : b0.BUSY;
  assign m_done   = use1 ? b1.DONE : b0.DONE;
  assign m_sclk   = use1 ? b1.SCLK : b0.SCLK;
  assign m_mosi   = use1 ? b1.MOSI : b0.MOSI;
  assign m_ssn    = use1 ? b1.SS_N : b0.SS_N;
  assign m_shld   = use1 ? b1.SH_LD : b0.SH_LD;
  assign m_te     = use1 ? b1.TE : b0.TE;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: last-granted requester and the previous LOAD cycle.
  int     last_g;
  longint prev_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Captured frame summary.
  logic [1:0] c_gnt;
  logic [7:0] c_byte;
  logic [3:0] c_bc_gap;
  int         c_ssn, c_te, c_dones, c_rises, c_toggles, c_gap;
  longint     c_load;
  bit         c_ok;

  // Follows one frame from LOAD until BUSY drops, sampling on falling clk edges.
  task automatic capture(input int pulse_at, input bit drop);
    int   n;
    logic prev;
    c_ok = 1'b0; c_gnt = 2'b00; c_byte = 8'h00; c_bc_gap = 4'h0;
    c_ssn = 0; c_te = 0; c_dones = 0; c_rises = 0; c_toggles = 0; c_gap = 0; c_load = 0;
    for (n = 0; n < 300 && m_gnt == 2'b00; n++) @(negedge clk);
    if (m_gnt == 2'b00) return;
    c_gnt  = m_gnt;
    c_load = cyc;
    check("load_sh_ld", {31'd0, m_shld}, 32'd0);
    if (drop) req = 2'b00;
    prev = m_sclk;
    n = 0;
    while (m_busy && n < 2000) begin
      if (!m_ssn) c_ssn++;
      if (m_te) c_te++;
      if (m_ssn) c_gap++;
      if (m_done) begin
        c_dones++;
        c_bc_gap = m_bitcnt;
      end
      if (m_sclk != prev) c_toggles++;
      if (m_sclk && !prev) begin
        c_rises++;
        c_byte = {c_byte[6:0], m_mosi};
      end
      prev = m_sclk;
      if (n == pulse_at) req = 2'b11;
      else if (pulse_at >= 0 && n == pulse_at + 1) req = 2'b00;
      n++;
      @(negedge clk);
    end
    c_ok = !m_busy;
  endtask

  // Drives one request pattern, predicts the frame and compares it.
  task automatic frame(input string tag, input logic [1:0] rq, input bit drop, input int pulse_at,
                       input int div, input int gapc, input bit chk_spacing);
    int         g;
    logic [7:0] exp_byte;
    req = rq;
    if (rq == 2'b01)      g = 0;
    else if (rq == 2'b10) g = 1;
    else                  g = 1 - last_g;
    exp_byte = (g == 1) ? d1 : d0;
    capture(pulse_at, drop);
    check({tag, "_done_ok"}, {31'd0, c_ok}, 32'd1);
    check({tag, "_gnt"}, {30'd0, c_gnt}, (g == 1) ? 32'd2 : 32'd1);
    check({tag, "_byte"}, {24'd0, c_byte}, {24'd0, exp_byte});
    check({tag, "_ssn_low"}, c_ssn, 1 + 2 * div * 8);
    check({tag, "_shift_len"}, c_te, 2 * div * 8);
    check({tag, "_rises"}, c_rises, 8);
    check({tag, "_toggles"}, c_toggles, 16);
    check({tag, "_dones"}, c_dones, 1);
    check({tag, "_gap_len"}, c_gap, gapc);
    check({tag, "_bitcnt_gap"}, {28'd0, c_bc_gap}, 32'd8);
    if (chk_spacing) check({tag, "_spacing"}, 32'(c_load - prev_load), 1 + 2 * div * 8 + gapc + 1);
    prev_load = c_load;
    last_g = g;
  endtask

  initial begin
    int         n;
    int         rises;
    int         seen;
    logic       prev;
    logic [1:0] rq;
    use1 = 1'b0; req = 2'b00; d0 = 8'h00; d1 = 8'h00;
    clr0 = 1'b0; clr1 = 1'b0;
    last_g = 1; prev_load = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_sclk", {31'd0, m_sclk}, 32'd0);
    check("rst_mosi", {31'd0, m_mosi}, 32'd0);
    check("rst_ss_n", {31'd0, m_ssn}, 32'd1);
    check("rst_gnt", {30'd0, m_gnt}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_sh_ld", {31'd0, m_shld}, 32'd1);
    check("rst_te", {31'd0, m_te}, 32'd0);
    check("rst_bitcnt", {28'd0, m_bitcnt}, 32'd0);
    clr0 = 1'b1;
    @(negedge clk);

    // Single request from requester 0.
    d0 = 8'hA5;
    frame("a5", 2'b01, 1'b1, -1, 4, 2, 1'b0);

    // Both requesting continuously: alternating grants, back-to-back frames.
    d0 = 8'h3C; d1 = 8'hC3;
    frame("rr0", 2'b11, 1'b0, -1, 4, 2, 1'b0);
    for (int k = 1; k < 4; k++) frame("rr", 2'b11, 1'b0, -1, 4, 2, 1'b1);

    // Requester 1 alone, all ones.
    d1 = 8'hFF;
    frame("ff", 2'b10, 1'b1, -1, 4, 2, 1'b0);

    // Randomized request patterns and payloads.
    for (int k = 0; k < 8; k++) begin
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      rq = 2'(1 + $urandom_range(0, 2));
      frame("rnd", rq, 1'($urandom_range(0, 1)), -1, 4, 2, 1'b0);
    end

    // Request pulse during SHIFT only must not start another frame.
    d0 = 8'($urandom);
    frame("pulse", 2'b01, 1'b1, 20, 4, 2, 1'b0);
    seen = 0;
    for (n = 0; n < 20; n++) begin
      if (m_busy || m_gnt != 2'b00) seen++;
      @(negedge clk);
    end
    check("pulse_no_frame", seen, 0);

    // Reset after the third SCLK rise aborts the frame.
    d1 = 8'($urandom);
    req = 2'b10;
    for (n = 0; n < 300 && m_gnt == 2'b00; n++) @(negedge clk);
    check("abort_gnt", {30'd0, m_gnt}, 32'd2);
    rises = 0;
    prev = m_sclk;
    for (n = 0; n < 300 && rises < 3; n++) begin
      @(negedge clk);
      if (m_sclk && !prev) rises++;
      prev = m_sclk;
    end
    check("abort_rises", rises, 3);
    clr0 = 1'b0;
    #1;
    check("abort_ss_n", {31'd0, m_ssn}, 32'd1);
    check("abort_sclk", {31'd0, m_sclk}, 32'd0);
    check("abort_busy", {31'd0, m_busy}, 32'd0);
    check("abort_done", {31'd0, m_done}, 32'd0);
    check("abort_bitcnt", {28'd0, m_bitcnt}, 32'd0);
    @(negedge clk);
    clr0 = 1'b1;
    last_g = 1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    frame("post_rst", 2'b11, 1'b1, -1, 4, 2, 1'b0);

    // Fastest setting: DIV = 1, GAP = 1.
    use1 = 1'b1;
    clr1 = 1'b1;
    last_g = 1;
    @(negedge clk);
    d0 = 8'h81;
    frame("div1", 2'b01, 1'b1, -1, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
